load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the CPU datapath (MEM stage) and the word-only data memory. Adds byte/halfword
//  loads (sign/zero extended) and byte/halfword stores via a two-cycle read-modify-write. Word
//  accesses pass straight through with no added latency. Stalls the CPU while a sub-word store runs.
// PARAMETERS
//  ADDR_W  32  byte-address width of CPU and memory side
//  DATA_W  32  data width; only 32 is supported
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       synchronous reset, active-high
//  memRead       in   1       CPU load request
//  memWrite      in   1       CPU store request
//  funct3        in   3       size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU load-only)
//  addr          in   ADDR_W  CPU byte address
//  writeData     in   DATA_W  CPU store data (low byte/half used for SB/SH)
//  readData      out  DATA_W  aligned, extended load result (combinational)
//  stall         out  1       hold CPU pipeline; inputs must stay stable while high
//  misaligned    out  1       misaligned access flag (MISALIGN_TRAP_EN only, else tied 0)
//  mem_addr      out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
//  mem_writeData out  DATA_W  word written to memory
//  mem_memWrite  out  1       memory write enable
//  mem_readData  in   DATA_W  combinational read word from memory
// BEHAVIOUR
//  - Reset: state=IDLE, stall=0, mem_memWrite=0, misaligned=0, merge register=0.
//  - Loads: zero latency. Byte lane = addr[1:0]; half lane = addr[1]. B/H sign-extend, BU/HU
//    zero-extend, W passes the word. readData is don't-care when memRead=0, but stays driven.
//  - SW: written in the same cycle from IDLE (mem_memWrite=1, mem_writeData=writeData), no stall.
//  - SB/SH FSM: IDLE -> MERGE on sub-word store: stall=1, mem_memWrite=0. At the clock edge, latch
//    mem_readData with the byte/half lane replaced by writeData[7:0]/[15:0]. MERGE -> IDLE: drive
//    the latched word, mem_memWrite=1, stall=0. Total 2 cycles, exactly one memory write.
//  - memRead and memWrite both high: the store takes priority, and readData still reflects the
//    current memory word.
//  - funct3 011/110/111, or BU/HU on a store: no write, no stall; a load returns 0.
//  - rst in MERGE: abort. No write is issued, and the next cycle is IDLE with stall=0.
//  - Address bits above ADDR_W wrap naturally; mem_addr is never modified except for the low 2 bits.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: H with addr[0]=1, or W with addr[1:0]!=0, sets misaligned=1 in the
//    same cycle (combinational). A misaligned load returns 0. A misaligned store gives no write and
//    no stall, and the FSM stays IDLE.
//  MISALIGN_TRAP_EN undefined: misaligned=0. Low address bits below the access size are ignored:
//    H uses addr[1], W uses the word.
// STRUCTURE
//  - lsu_pkg: funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum {ST_IDLE, ST_MERGE},
//    lane-merge function.
//  - One sub-module, lsu_load_align: combinational lane select plus sign/zero extend, used for
//    readData.
//  - FSM and merge register live in load_store_unit.
// TESTING (preload word 0 = 0xCAD9C562)
//  1. LB at 0x3 -> readData 0xFFFFFFCA. LBU at 0x3 -> 0x000000CA. Both with stall=0.
//  2. LH at 0x0 -> 0xFFFFC562. LHU at 0x2 -> 0x0000CAD9.
//  3. SB 0x5A at 0x1 -> cycle 1: stall=1, no write. Cycle 2: write 0xCAD95A62, stall=0.
//     Subsequent LW at 0x0 -> 0xCAD95A62.
//  4. SW 0x12345678 at 0x10 -> written in one cycle, stall never high. LW at 0x10 -> 0x12345678.
//  5. SH 0xBEEF at 0x2, rst pulsed during MERGE -> no write, stall=0, word 0 unchanged.
//     Retried SH -> 0xBEEFC562.
//  6. With MISALIGN_TRAP_EN: LW at 0x2 -> misaligned=1, readData=0. SH at 0x1 -> misaligned=1,
//     no write, stall=0.
//     Without the macro: SH 0xBEEF at 0x1 -> 0xCAD9BEEF.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and lane-merge helper for the load/store unit.
// Optional misaligned trapping in the top is enabled by MISALIGN_TRAP_EN.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE,
        ST_MERGE
    } lsu_state_e;

    // Replace the byte or half lane of a memory word with store data.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] word,
        input logic [1:0]  lo,
        input logic [2:0]  f3,
        input logic [31:0] wdata
    );
        logic [31:0] r;
        r = word;
        if (f3 == F3_B)
            r[{lo, 3'b000} +: 8] = wdata[7:0];
        else if (f3 == F3_H)
            r[{lo[1], 4'b0000} +: 16] = wdata[15:0];
        return r;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select with sign/zero extension.
// Unsupported size codes yield zero.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lo,
    input  logic [2:0]  f3,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = word[{lo, 3'b000} +: 8];
    assign h = word[{lo[1], 4'b0000} +: 16];

    always_comb begin
        data = '0;
        unique case (1'b1)
            (f3 == F3_B):  data = {{24{b[7]}}, b};
            (f3 == F3_H):  data = {{16{h[15]}}, h};
            (f3 == F3_W):  data = word;
            (f3 == F3_BU): data = {24'd0, b};
            (f3 == F3_HU): data = {16'd0, h};
            default:       data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store adapter for a word-only data memory.
// Define MISALIGN_TRAP_EN to flag and suppress misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              stall,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memWrite,
    input  logic [DATA_W-1:0] mem_readData
);

    lsu_state_e        state;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] aligned;
    logic              ld_size_ok;
    logic              st_word;
    logic              st_sub;
    logic              idle;

`ifdef MISALIGN_TRAP_EN
    logic is_half;
    logic is_word;
    assign is_half = (funct3 == F3_H) || (funct3 == F3_HU);
    assign is_word = (funct3 == F3_W);
    assign misaligned = (memRead || memWrite) &&
        ((is_half && addr[0]) || (is_word && addr[1:0] != 2'b00));
`else
    logic unused_rd;
    assign unused_rd  = memRead;
    assign misaligned = 1'b0;
`endif

    assign ld_size_ok = (funct3 == F3_B) || (funct3 == F3_H) ||
                        (funct3 == F3_W) || (funct3 == F3_BU) ||
                        (funct3 == F3_HU);

    assign idle    = (state == ST_IDLE);
    assign st_word = memWrite && !misaligned && (funct3 == F3_W);
    assign st_sub  = memWrite && !misaligned &&
                     ((funct3 == F3_B) || (funct3 == F3_H));

    lsu_load_align u_align (
        .word (mem_readData),
        .lo   (addr[1:0]),
        .f3   (funct3),
        .data (aligned)
    );

    assign readData = (ld_size_ok && !misaligned) ? aligned : '0;
    assign mem_addr = {addr[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            merge_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (st_sub) begin
                        state   <= ST_MERGE;
                        merge_q <= lane_merge(mem_readData, addr[1:0],
                                              funct3, writeData);
                    end
                end
                ST_MERGE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Reset gates the MERGE write so an aborted store never lands.
    assign stall         = !rst && idle && st_sub;
    assign mem_memWrite  = !rst && ((state == ST_MERGE) ||
                                    (idle && st_word));
    assign mem_writeData = (state == ST_MERGE) ? merge_q : writeData;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit.
// Byte-array reference model plus directed and random accesses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        misaligned;
    logic [31:0] mem_addr;
    logic [31:0] mem_writeData;
    logic        mem_memWrite;
    logic [31:0] mem_readData;

    logic [31:0] mem [64];
    logic [7:0]  refm [256];
    int          wr_cnt = 0;
    int          tests = 0;
    int          fails = 0;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk           (clk),
        .rst           (rst),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .funct3        (funct3),
        .addr          (addr),
        .writeData     (writeData),
        .readData      (readData),
        .stall         (stall),
        .misaligned    (misaligned),
        .mem_addr      (mem_addr),
        .mem_writeData (mem_writeData),
        .mem_memWrite  (mem_memWrite),
        .mem_readData  (mem_readData)
    );

    assign mem_readData = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_memWrite) begin
            mem[mem_addr[7:2]] <= mem_writeData;
            wr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ref_word_at(input int a);
        int w;
        w = a - (a % 4);
        return {refm[w+3], refm[w+2], refm[w+1], refm[w]};
    endfunction

    function automatic bit ref_mis(input logic [2:0] f3, input int a);
        if (!TRAP) return 1'b0;
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2) != 0) return 1'b1;
        if (f3 == 3'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input int a);
        int v;
        int h;
        if (ref_mis(f3, a)) return 32'd0;
        h = a - (a % 2);
        case (f3)
            3'd0: begin
                v = refm[a];
                if (v > 127) v -= 256;
                return 32'(v);
            end
            3'd4: return 32'(int'(refm[a]));
            3'd1, 3'd5: begin
                v = refm[h+1] * 256 + refm[h];
                if (f3 == 3'd1 && v > 32767) v -= 65536;
                return 32'(v);
            end
            3'd2: return 32'(ref_word_at(a));
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input int a,
                             input logic [31:0] wd);
        int h;
        int w;
        h = a - (a % 2);
        w = a - (a % 4);
        if (f3 == 3'd0) begin
            refm[a] = wd[7:0];
        end else if (f3 == 3'd1) begin
            refm[h]   = wd[7:0];
            refm[h+1] = wd[15:8];
        end else begin
            for (int i = 0; i < 4; i++) refm[w+i] = wd[8*i +: 8];
        end
    endtask

    task automatic set_word0(input logic [31:0] v);
        mem[0] = v;
        for (int i = 0; i < 4; i++) refm[i] = v[8*i +: 8];
    endtask

    task automatic go_idle();
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    task automatic drive(input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        memRead   = rd;
        memWrite  = wr;
        funct3    = f3;
        addr      = a;
        writeData = wd;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a,
                           input string tag, output logic [31:0] got);
        int lo;
        lo = int'(a[7:0]);
        drive(1'b1, 1'b0, f3, a, $urandom());
        @(negedge clk);
        got = readData;
        chk({tag, ".data"}, readData, ref_load(f3, lo));
        chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
        chk({tag, ".maddr"}, mem_addr, a & ~32'd3);
        chk({tag, ".mis"}, {31'd0, misaligned},
            {31'd0, ref_mis(f3, lo)});
        @(posedge clk);
        #1;
        go_idle();
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic rd,
                            input string tag);
        int lo;
        int w0;
        bit sub;
        bit word;
        lo   = int'(a[7:0]);
        sub  = (f3 == 3'd0 || f3 == 3'd1) && !ref_mis(f3, lo);
        word = (f3 == 3'd2) && !ref_mis(f3, lo);
        w0   = wr_cnt;
        drive(rd, 1'b1, f3, a, wd);
        @(negedge clk);
        if (rd) chk({tag, ".rdata"}, readData, ref_load(f3, lo));
        chk({tag, ".stall1"}, {31'd0, stall}, {31'd0, sub});
        chk({tag, ".we1"}, {31'd0, mem_memWrite}, {31'd0, word});
        if (word) begin
            chk({tag, ".wdata"}, mem_writeData, wd);
            ref_store(f3, lo, wd);
        end
        @(posedge clk);
        #1;
        if (sub) begin
            ref_store(f3, lo, wd);
            @(negedge clk);
            chk({tag, ".stall2"}, {31'd0, stall}, 32'd0);
            chk({tag, ".we2"}, {31'd0, mem_memWrite}, 32'd1);
            chk({tag, ".merged"}, mem_writeData,
                32'(ref_word_at(lo)));
            @(posedge clk);
            #1;
        end
        go_idle();
        chk({tag, ".nwr"}, 32'(wr_cnt - w0), {31'd0, sub | word});
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [2:0]  f3;
        int          w0;

        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom();
            for (int j = 0; j < 4; j++) refm[4*i+j] = mem[i][8*j +: 8];
        end
        set_word0(32'hCAD9C562);

        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd2, 32'd0, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("rst.stall", {31'd0, stall}, 32'd0);
        chk("rst.we", {31'd0, mem_memWrite}, 32'd0);
        chk("rst.mis", {31'd0, misaligned}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_load(3'd0, 32'h3, "lb3", got);
        chk("lb3.const", got, 32'hFFFFFFCA);
        do_load(3'd4, 32'h3, "lbu3", got);
        chk("lbu3.const", got, 32'h000000CA);
        do_load(3'd1, 32'h0, "lh0", got);
        chk("lh0.const", got, 32'hFFFFC562);
        do_load(3'd5, 32'h2, "lhu2", got);
        chk("lhu2.const", got, 32'h0000CAD9);

        do_store(3'd0, 32'h1, 32'hFFFFFF5A, 1'b0, "sb1");
        do_load(3'd2, 32'h0, "lw0", got);
        chk("lw0.const", got, 32'hCAD95A62);

        do_store(3'd2, 32'h10, 32'h12345678, 1'b1, "sw10");
        do_load(3'd2, 32'h10, "lw10", got);
        chk("lw10.const", got, 32'h12345678);

        set_word0(32'hCAD9C562);
        w0 = wr_cnt;
        drive(1'b0, 1'b1, 3'd1, 32'h2, 32'h0000BEEF);
        @(negedge clk);
        chk("abort.stall1", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort.we", {31'd0, mem_memWrite}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        go_idle();
        @(negedge clk);
        chk("abort.stall", {31'd0, stall}, 32'd0);
        chk("abort.nwr", 32'(wr_cnt - w0), 32'd0);
        chk("abort.word0", mem[0], 32'hCAD9C562);
        @(posedge clk);
        #1;
        do_store(3'd1, 32'h2, 32'h0000BEEF, 1'b0, "shretry");
        chk("shretry.word0", mem[0], 32'hBEEFC562);

        set_word0(32'hCAD9C562);
`ifdef MISALIGN_TRAP_EN
        do_load(3'd2, 32'h2, "lwmis", got);
        chk("lwmis.const", got, 32'd0);
        drive(1'b0, 1'b1, 3'd1, 32'h1, 32'h0000BEEF);
        @(negedge clk);
        chk("shmis.mis", {31'd0, misaligned}, 32'd1);
        go_idle();
        @(posedge clk);
        #1;
        do_store(3'd1, 32'h1, 32'h0000BEEF, 1'b0, "shmis");
        chk("shmis.word0", mem[0], 32'hCAD9C562);
`else
        do_store(3'd1, 32'h1, 32'h0000BEEF, 1'b0, "sh1");
        chk("sh1.word0", mem[0], 32'hCAD9BEEF);
`endif

        do_load(3'd3, 32'h4, "ld011", got);
        chk("ld011.zero", got, 32'd0);
        do_store(3'd4, 32'h8, 32'h11223344, 1'b0, "sbu");
        do_store(3'd7, 32'hC, 32'h55667788, 1'b1, "s111");

        for (int n = 0; n < 300; n++) begin
            a  = {$urandom_range(0, 32'hFFFFFF), 8'($urandom_range(0, 255))};
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0)
                do_load(f3, a, "rnd.ld", got);
            else
                do_store(f3, a, $urandom(), 1'($urandom_range(0, 1)),
                         "rnd.st");
        end

        for (int i = 0; i < 64; i++)
            chk("final.mem", mem[i], 32'(ref_word_at(4 * i)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
